// File: rtl/ssd_ctrl_n.sv
// Multiplexed seven-segment display controller: hex decode, decimal points, leading-zero
// blanking, PWM brightness and frame-synchronous double buffering of the displayed value.
module ssd_ctrl_n #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 262144,
  parameter int DIM_BITS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lz_blank,
  input  logic [DIM_BITS-1:0]     i_bright,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic [6:0]              o_led,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int TW = $clog2(TICKS_PER_DIGIT);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam int SW = VW + NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  // Internal logic is active-low; XOR with these masks yields the board polarity.
  localparam logic [NUM_DIGITS-1:0] EN_POL  = {NUM_DIGITS{!ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL = {7{!ACTIVE_LOW}};
  localparam logic                  DP_POL  = !ACTIVE_LOW;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [TW-1:0]         r_tick_p0;
  logic [IW-1:0]         r_idx_p0;
  logic [SW-1:0]         r_shadow;
  logic [SW-1:0]         r_active;
  logic                  r_pending;

  logic                  w_tick_last;
  logic                  w_idx_last;
  logic                  w_boundary;

  logic [VW-1:0]         w_act_val;
  logic [NUM_DIGITS-1:0] w_act_dp;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_blank;
  logic                  w_lz_run;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_on;
  logic [NUM_DIGITS-1:0] w_en_n;
  logic [6:0]            w_seg_n;
  logic                  w_dp_n;

  logic [NUM_DIGITS-1:0] r_digit_en_p1;
  logic [6:0]            r_led_p1;
  logic                  r_dp_p1;
  logic                  r_frame_p1;

  assign w_tick_last = (r_tick_p0 == TICK_LAST);
  assign w_idx_last  = (r_idx_p0 == IDX_LAST);
  assign w_boundary  = w_tick_last && w_idx_last;

  // ---- stage p0: scan counters and frame-synchronous buffering ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_p0 <= '0;
      r_idx_p0  <= '0;
    end else begin
      if (w_tick_last) begin
        r_tick_p0 <= '0;
        r_idx_p0  <= w_idx_last ? '0 : r_idx_p0 + IW'(1);
      end else begin
        r_tick_p0 <= r_tick_p0 + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= {i_value, i_dp};
      end
      // A load landing on the boundary bypasses the shadow so it shows in the next frame.
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (i_load) begin
          r_active <= {i_value, i_dp};
        end else if (r_pending) begin
          r_active <= r_shadow;
        end
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_act_val = r_active[SW-1:NUM_DIGITS];
  assign w_act_dp  = r_active[NUM_DIGITS-1:0];

  // Digit selection and leading-zero run; digit 0 is leftmost and sits in the top nibble.
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    w_onehot = '0;
    w_lz_run = i_lz_blank;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_lz_run = w_lz_run && (w_act_val[4*(NUM_DIGITS-1-d) +: 4] == 4'h0);
      if (r_idx_p0 == IW'(d)) begin
        w_nib                      = w_act_val[4*(NUM_DIGITS-1-d) +: 4];
        w_dp_sel                   = w_act_dp[NUM_DIGITS-1-d];
        w_blank                    = w_lz_run && (d != NUM_DIGITS - 1);
        w_onehot[NUM_DIGITS-1-d]   = 1'b1;
      end
    end
  end

  // Tick 0 of every slot is dark so the previous digit's segments never ghost onto the next anode.
  assign w_on    = (r_tick_p0 != '0) && (r_tick_p0[TW-1 -: DIM_BITS] <= i_bright);
  assign w_en_n  = w_on ? ~w_onehot : '1;
  assign w_seg_n = w_blank ? 7'h7F : hex_to_seg_n(w_nib);
  assign w_dp_n  = ~w_dp_sel;

  // ---- stage p1: registered pin drivers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit_en_p1 <= '1 ^ EN_POL;
      r_led_p1      <= 7'h7F ^ SEG_POL;
      r_dp_p1       <= 1'b1 ^ DP_POL;
      r_frame_p1    <= 1'b0;
    end else begin
      r_digit_en_p1 <= w_en_n ^ EN_POL;
      r_led_p1      <= w_seg_n ^ SEG_POL;
      r_dp_p1       <= w_dp_n ^ DP_POL;
      r_frame_p1    <= w_boundary;
    end
  end

  assign o_digit_en = r_digit_en_p1;
  assign o_led      = r_led_p1;
  assign o_dp       = r_dp_p1;
  assign o_frame    = r_frame_p1;

endmodule

// File: tb/tb_ssd_ctrl_n.sv
// Bench for ssd_ctrl_n: directed scenarios plus randomized loads, checked against a
// cycle-count based reference model of scanning, buffering and decode.
module tb_ssd_ctrl_n;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int DB = 2;
  localparam int FRAME = N * T;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_load = 1'b0;
  logic [15:0]   i_value = '0;
  logic [3:0]    i_dp = '0;
  logic          i_lz_blank = 1'b0;
  logic [DB-1:0] i_bright = '1;
  logic [3:0]    o_digit_en;
  logic [6:0]    o_led;
  logic          o_dp;
  logic          o_frame;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: cycles since reset release, displayed and buffered words.
  int          m_cyc;
  logic [19:0] m_act;
  logic [19:0] m_shadow;
  bit          m_pend;

  ssd_ctrl_n #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .DIM_BITS(DB), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_value(i_value), .i_dp(i_dp),
    .i_lz_blank(i_lz_blank), .i_bright(i_bright), .o_digit_en(o_digit_en),
    .o_led(o_led), .o_dp(o_dp), .o_frame(o_frame));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, m_cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_act    = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  // One clock: apply inputs, predict the registered outputs, advance the model, compare.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp);
    int         t, d, nib;
    bit         on, allz, blank;
    logic [3:0] e_en;
    logic [6:0] e_led;
    logic       e_dp, e_frame;
    i_load  = ld;
    i_value = v;
    i_dp    = dp;
    t  = m_cyc % T;
    d  = (m_cyc / T) % N;
    on = (t != 0) && ((t / (T >> DB)) <= int'(i_bright));
    e_en = on ? ~(4'b1000 >> d) : 4'hF;
    allz = 1'b1;
    for (int k = 0; k <= d; k++)
      if (((m_act[19:4] >> (4 * (N - 1 - k))) & 16'hF) != 0) allz = 1'b0;
    blank = i_lz_blank && allz && (d != N - 1);
    nib   = int'((m_act[19:4] >> (4 * (N - 1 - d))) & 16'hF);
    e_led = blank ? 7'h7F : SEG_TAB[nib];
    e_dp  = ~m_act[N - 1 - d];
    e_frame = ((m_cyc % FRAME) == FRAME - 1);
    if (e_frame) begin
      if (ld) m_act = {v, dp};
      else if (m_pend) m_act = m_shadow;
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    if (ld) m_shadow = {v, dp};
    m_cyc++;
    @(posedge clk);
    #1;
    chk("digit_en", 32'(o_digit_en), 32'(e_en));
    chk("frame", 32'(o_frame), 32'(e_frame));
    if (e_en != 4'hF) begin
      chk("led", 32'(o_led), 32'(e_led));
      chk("dp", 32'(o_dp), 32'(e_dp));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, i_value, i_dp);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != phase; i++) step(1'b0, i_value, i_dp);
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_en"}, 32'(o_digit_en), 32'hF);
    chk({tag, "_led"}, 32'(o_led), 32'h7F);
    chk({tag, "_dp"}, 32'(o_dp), 32'h1);
    chk({tag, "_frame"}, 32'(o_frame), 32'h0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_inactive("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset release and first load; display stays zero until the boundary.
    i_bright = 2'd3;
    step(1'b1, 16'h12AF, 4'b0000);
    run(2 * FRAME);

    // Leading-zero blanking with a dp on a blanked digit, then all zeros.
    i_lz_blank = 1'b1;
    step(1'b1, 16'h0005, 4'b0100);
    run(2 * FRAME);
    step(1'b1, 16'h0000, 4'b0000);
    run(2 * FRAME);
    i_lz_blank = 1'b0;

    // Tear-free back-to-back loads mid-frame.
    run_to(20);
    step(1'b1, 16'h1111, 4'b0000);
    step(1'b1, 16'h2222, 4'b0000);
    run(2 * FRAME);

    // Load exactly on the boundary cycle.
    run_to(FRAME - 1);
    step(1'b1, 16'h3333, 4'b1010);
    run(FRAME);

    // Brightness sweep.
    i_bright = 2'd0;
    run(FRAME);
    i_bright = 2'd2;
    run(FRAME);
    i_bright = 2'd1;
    run(FRAME);
    i_bright = 2'd3;

    // Async reset mid-frame with a load pending.
    run_to(10);
    step(1'b1, 16'h4444, 4'b1111);
    run(5);
    #2 rst = 1'b1;
    #1;
    chk_inactive("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    i_load = 1'b0;
    run(2 * FRAME);

    // Randomized loads, brightness and blanking.
    for (int i = 0; i < 2500; i++) begin
      logic [15:0] mask, v;
      if ($urandom_range(0, 15) == 0) i_bright = DB'($urandom);
      if ($urandom_range(0, 199) == 0) i_lz_blank = ~i_lz_blank;
      case ($urandom_range(0, 4))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        3: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      v = 16'($urandom) & mask;
      step($urandom_range(0, 39) == 0, v, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_ctrl_n.md
Name: ssd_ctrl_n

Overview:
Parametrised multiplexed seven-segment display controller for NUM_DIGITS digits.
- Decodes full hex (0-F) per digit, with per-digit decimal points, optional leading-zero blanking and PWM brightness.
- Values load through a one-cycle load strobe and are double-buffered, so they change only at frame boundaries (no tearing).
- Sits between status/counter logic and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 2..8.
- TICKS_PER_DIGIT, 262144, clk cycles each digit is selected; power of two, >= 2**DIM_BITS.
- DIM_BITS, 4, width of the brightness input.
- ACTIVE_LOW, 1, 1 = anodes/segments/dp driven active-low; 0 = all outputs inverted (active-high).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- i_load  input  1  one-cycle strobe; captures i_value/i_dp into shadow register
- i_value  input  4*NUM_DIGITS  hex nibbles; [4*NUM_DIGITS-1 -: 4] is leftmost digit
- i_dp  input  NUM_DIGITS  decimal point per digit; MSB is leftmost digit
- i_lz_blank  input  1  1 = blank leading zeros
- i_bright  input  DIM_BITS  brightness; all-ones = full on, 0 = minimum (1/2**DIM_BITS duty)
- o_digit_en  output  NUM_DIGITS  anode enables; MSB is leftmost digit
- o_led  output  7  segments {g,f,e,d,c,b,a}
- o_dp  output  1  decimal point segment
- o_frame  output  1  one-cycle pulse after each completed frame

Behaviour:
- Reset (async): tick_cnt=0, digit_idx=0, shadow=0, active=0, pending=0, o_frame=0. All outputs at the inactive level: o_digit_en all ones, o_led=7'h7F, o_dp=1 for ACTIVE_LOW=1; complements for ACTIVE_LOW=0.
- tick_cnt counts 0..TICKS_PER_DIGIT-1 and wraps.
  - On wrap, digit_idx increments 0..NUM_DIGITS-1 and wraps to 0.
  - digit_idx 0 = leftmost digit.
- Frame boundary: the cycle with tick_cnt==TICKS_PER_DIGIT-1 and digit_idx==NUM_DIGITS-1.
- Load:
  - i_load=1 captures {i_value,i_dp} into shadow and sets pending.
  - Back-to-back loads: the last one wins.
- Transfer at a frame boundary:
  - If pending or i_load, then active<=(i_load ? i_value/i_dp : shadow) and pending clears.
  - A load in the boundary cycle is applied at that boundary.
- o_frame=1 the cycle after each frame boundary.
- Decode, active-low polarity: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (i_lz_blank=1):
  - A digit is blanked (segments off) if it and all digits to its left are 0.
  - The rightmost digit is never blanked.
  - The dp of a blanked digit still follows i_dp.
- Brightness: the selected anode is enabled only while tick_cnt[top DIM_BITS bits] <= i_bright; otherwise all anodes are off. i_bright is sampled live.
- Ghosting guard: all anodes are off when tick_cnt==0 of every digit slot.
- Output latency: o_digit_en/o_led/o_dp are registered, valid 1 cycle after the counter state that produces them.
- Outputs are glitch-free (straight from flops).
- Only one anode bit is active at any time.
- Reset mid-frame or mid-load: pending and shadow are discarded; the display returns to blank/zero and scanning restarts at digit 0.

Test Plan:
Bench configuration: NUM_DIGITS=4, TICKS_PER_DIGIT=16, DIM_BITS=2, ACTIVE_LOW=1.
- Reset release:
  - Stimulus: release reset, then i_load with i_value=16'h12AF, i_dp=0, i_bright=3.
  - Required response: no change until the next frame boundary. After it, o_digit_en cycles 0111/1011/1101/1110 for 16 cycles each (enabled cycles 2..16 of each slot), with o_led=1111001, 0100100, 0001000, 0001110 respectively.
- Leading-zero blanking:
  - Stimulus: i_value=16'h0005, i_lz_blank=1, i_dp=4'b0100.
  - Required response: digits 0 and 1 have o_led=1111111; digit 1 has o_dp=0; digit 3 shows 0010010.
  - Stimulus: i_value=16'h0000.
  - Required response: only digit 3 shows 1000000.
- Tear-free loading:
  - Stimulus: i_load=16'h1111 mid-frame, then i_load=16'h2222 next cycle.
  - Required response: the current frame finishes showing the old value; the next frame shows 2 on all digits; o_frame pulses once per 64 cycles.
- Load at boundary:
  - Stimulus: i_load=16'h3333 asserted exactly on the boundary cycle.
  - Required response: the very next frame shows 3333.
- Brightness:
  - Stimulus: i_bright=0.
  - Required response: each digit's anode is enabled only for tick_cnt 1..3 (3 of 16 cycles).
  - Stimulus: i_bright=2.
  - Required response: the anode is enabled for tick_cnt 1..11.
- Async reset mid-frame:
  - Stimulus: assert rst asynchronously mid-frame with a load pending.
  - Required response: outputs go inactive immediately (all ones), without waiting for a clock edge. After release, the pending value is not displayed and scanning starts at digit 0 showing 0000.
